mult_result_collector: RTL and testbench
========================================

MULT_RESULT_COLLECTOR -- requirements
Module: mult_result_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the result FIFO depth; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter SEQ_W, default 8, giving the sequence-tag width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; it SHALL be synchronous and active-low (rst=0 resets at the next rising edge of clk).
REQ-005 op_a  input  8  multiplicand presented to the multiplier's in1.
REQ-006 op_b  input  8  multiplier operand presented to the multiplier's in2.
REQ-007 op_live  input  1  marks op_a/op_b as a real operation for the current 10-cycle slot.
REQ-008 mult_out  input  16  accumulator output of the upstream shift-add multiplier.
REQ-009 res_valid  output  1  FIFO head holds a result.
REQ-010 res_ready  input  1  consumer accepts the head this cycle.
REQ-011 res_data  output  16  product at the FIFO head.
REQ-012 res_a  output  8  op_a belonging to the head entry.
REQ-013 res_b  output  8  op_b belonging to the head entry.
REQ-014 res_seq  output  SEQ_W  sequence tag of the head entry.
REQ-015 phase  output  4  mirrored multiplier stage, 0..9.
REQ-016 overflow  output  1  sticky flag set when a result is dropped.
REQ-017 drop_count  output  8  saturating count of dropped results.

Function
REQ-018 phase SHALL increment by 1 each cycle and wrap from 9 to 0; it SHALL track the multiplier stage when the multiplier reset is driven by ~rst.
REQ-019 On the edge where phase==0, the block SHALL latch op_a, op_b and op_live into slot registers; this is the same edge on which the multiplier samples its operands.
REQ-020 On the edge where phase==9 with slot_live=1, the block SHALL push {mult_out, slot_a, slot_b, seq} into the FIFO; this edge SHALL be the only capture point.
REQ-021 Latency SHALL be fixed: operands are sampled on the phase-0 edge, the product is captured 9 edges later, and res_valid is high in the following cycle if the FIFO was empty.
REQ-022 seq SHALL increment (mod 2^SEQ_W) once per live slot, whether the push succeeds or the result is dropped, so that the consumer can detect gaps.
REQ-023 When slot_live=0 at phase 9, there SHALL be no push and seq SHALL hold.
REQ-024 A pop SHALL occur when res_valid and res_ready are both high.
REQ-025 The FIFO SHALL be show-ahead: the head fields are valid in the same cycle as res_valid.
REQ-026 The head fields SHALL be stable while res_valid=1 and res_ready=0.
REQ-027 When the FIFO is empty, res_valid SHALL be 0 and res_ready SHALL be ignored.
REQ-028 Push while full with no pop in the same cycle: the entry SHALL be dropped, overflow SHALL be set to 1, and drop_count SHALL increment, saturating at 255.
REQ-029 Push while full with a pop in the same cycle: the push SHALL be accepted and the occupancy SHALL stay DEPTH.
REQ-030 Push while empty with res_ready=1: the entry SHALL appear in the next cycle; there SHALL be no same-cycle bypass.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH.
REQ-032 Occupancy SHALL never exceed DEPTH or go below 0.
REQ-033 overflow SHALL clear only on reset.

Reset
REQ-034 On rst=0 at a clock edge, the block SHALL clear phase, the slot registers, the FIFO pointers and occupancy, seq, overflow and drop_count.
REQ-035 After that edge, res_valid SHALL be 0 and res_data, res_a, res_b and res_seq SHALL all read 0.
REQ-036 Reset asserted mid-slot (any phase) or with the FIFO non-empty SHALL discard all pending entries and the in-flight operation; phase SHALL read 0 in the first cycle after rst returns to 1.

Verification
REQ-037 Release reset, then op_a=13, op_b=11, op_live=1 at phase 0 -> after the phase-9 edge: res_valid=1, res_data=143, res_a=13, res_b=11, res_seq=0.
REQ-038 op_a=255, op_b=255 live -> res_data=0xFE01; op_a=0, op_b=200 live in the next slot -> res_data=0, res_seq=1.
REQ-039 op_live=0 for 3 slots -> res_valid stays 0 and seq is unchanged; the next live slot yields res_seq=0.
REQ-040 res_ready=0, 5 consecutive live slots, DEPTH=4 -> 4 entries with seq 0..3, fifth dropped, overflow=1, drop_count=1; after draining, the next live result has seq=5.
REQ-041 FIFO full with res_ready=1 on the phase-9 capture edge -> push accepted, occupancy stays 4, overflow stays 0.
REQ-042 Two entries queued, rst=0 at phase 5 -> res_valid=0, overflow=0, drop_count=0, and phase reads 0 in the first cycle after release.

Source files
------------

// File: rtl/mult_result_collector.sv
// Collects products from a free-running 10-stage shift-add multiplier. Operands are
// latched at phase 0, the product is captured at phase 9, and results queue in a show-ahead FIFO.
module mult_result_collector #(
  parameter int DEPTH = 4,   // must be a power of two, >= 2
  parameter int SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  input  logic             op_live,
  input  logic [15:0]      mult_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [7:0]       res_a,
  output logic [7:0]       res_b,
  output logic [SEQ_W-1:0] res_seq,
  output logic [3:0]       phase,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  // Handshake: a result transfers on any rising edge where res_valid && res_ready;
  // res_valid never depends on res_ready, and head fields hold while res_valid && !res_ready.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 16 + 8 + 8 + SEQ_W;
  localparam logic [3:0] LAST_PHASE = 4'd9;

  logic [7:0]       slot_a;
  logic [7:0]       slot_b;
  logic             slot_live;
  logic [SEQ_W-1:0] seq;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             drop;
  logic [EW-1:0]    head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign push_req   = (phase == LAST_PHASE) && slot_live;
  assign pop        = res_valid && res_ready;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  assign res_valid  = !fifo_empty;
  assign head       = mem[rd_ptr];

  // Head fields read zero when empty so reset leaves clean outputs without clearing storage.
  always_comb begin
    res_data = '0;
    res_a    = '0;
    res_b    = '0;
    res_seq  = '0;
    if (res_valid) begin
      res_data = head[EW-1 -: 16];
      res_a    = head[SEQ_W+15 -: 8];
      res_b    = head[SEQ_W+7 -: 8];
      res_seq  = head[SEQ_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase      <= '0;
      slot_a     <= '0;
      slot_b     <= '0;
      slot_live  <= 1'b0;
      seq        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      phase <= (phase == LAST_PHASE) ? 4'd0 : phase + 4'd1;

      if (phase == 4'd0) begin
        slot_a    <= op_a;
        slot_b    <= op_b;
        slot_live <= op_live;
      end

      // Sequence advances for every live slot, dropped or not, so gaps are visible downstream.
      if (push_req) begin
        seq <= seq + 1'b1;
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {mult_out, slot_a, slot_b, seq};
    end
  end

endmodule

// File: tb/tb_mult_result_collector.sv
// Bench for mult_result_collector: directed slots feed a scoreboard queue, a negedge
// monitor pops and compares every accepted result.
module tb_mult_result_collector;

  localparam int DEPTH = 4;
  localparam int SEQ_W = 8;

  logic             clk;
  logic             rst;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             op_live;
  logic [15:0]      mult_out;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [7:0]       res_a;
  logic [7:0]       res_b;
  logic [SEQ_W-1:0] res_seq;
  logic [3:0]       phase;
  logic             overflow;
  logic [7:0]       drop_count;

  mult_result_collector #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .op_live(op_live),
    .mult_out(mult_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_a(res_a), .res_b(res_b), .res_seq(res_seq),
    .phase(phase), .overflow(overflow), .drop_count(drop_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  tb_seq;
  logic [3:0]  tb_ph;
  logic [39:0] exp_e;

  // Independent model of the multiplier stage counter.
  always @(posedge clk) begin
    if (!rst) tb_ph <= 4'd0;
    else      tb_ph <= (tb_ph == 4'd9) ? 4'd0 : tb_ph + 4'd1;
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("phase_track", 40'(phase), 40'(tb_ph));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=0x%0h required=none",
                   {res_data, res_a, res_b, res_seq});
        end else begin
          exp_e = exp_q.pop_front();
          chk("head_entry", {res_data, res_a, res_b, res_seq}, exp_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called one step after a rising edge while phase==0; returns the same way one slot later.
  task automatic run_slot(input logic [7:0] a, input logic [7:0] b, input logic live,
                          input logic push, input logic rdy9);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    op_a = a; op_b = b; op_live = live; mult_out = 16'hDEAD;
    @(posedge clk); #1;
    op_a = 8'($urandom_range(0, 255));
    op_b = 8'($urandom_range(0, 255));
    op_live = !live;
    repeat (8) @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk("no_bypass_valid", 40'(res_valid), 40'd0);
    mult_out = p;
    if (push) exp_q.push_back({p, a, b, tb_seq});
    if (live) tb_seq = tb_seq + 8'd1;
    if (rdy9) res_ready = 1'b1;
    @(posedge clk); #1;
    if (rdy9) res_ready = 1'b0;
    mult_out = 16'hDEAD;
    op_live = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 40'(res_valid), 40'd0);
    chk({tag, "_head"}, {res_data, res_a, res_b, res_seq}, 40'd0);
    chk({tag, "_overflow"}, 40'(overflow), 40'd0);
    chk({tag, "_drops"}, 40'(drop_count), 40'd0);
    chk({tag, "_phase"}, 40'(phase), 40'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    tb_seq = 8'd0;
    check_reset_outputs("reset");
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; op_a = '0; op_b = '0; op_live = 1'b0;
    mult_out = 16'hDEAD; res_ready = 1'b0; tb_seq = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b1;

    // 13*11 with consumer stalled: fixed latency, head visible after capture.
    run_slot(8'd13, 8'd11, 1'b1, 1'b1, 1'b0);
    chk("lat_valid", 40'(res_valid), 40'd1);
    chk("lat_data", 40'(res_data), 40'd143);
    chk("lat_ab", 40'({res_a, res_b}), 40'({8'd13, 8'd11}));
    chk("lat_seq", 40'(res_seq), 40'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_hold", {res_data, res_a, res_b, res_seq}, {16'd143, 8'd13, 8'd11, 8'd0});
    repeat (7) @(posedge clk);
    #1;
    res_ready = 1'b1;
    run_slot(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("drain1", 40'(exp_q.size()), 40'd0);

    // Extremes of the operand range.
    do_reset();
    res_ready = 1'b1;
    run_slot(8'd255, 8'd255, 1'b1, 1'b1, 1'b0);
    chk("max_data", 40'(res_data), 40'hFE01);
    run_slot(8'd0, 8'd200, 1'b1, 1'b1, 1'b0);
    chk("zero_data", 40'(res_data), 40'd0);
    chk("zero_seq", 40'(res_seq), 40'd1);
    run_slot(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Idle slots push nothing and leave seq alone.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_slot(8'(i + 40), 8'(i + 3), 1'b0, 1'b0, 1'b0);
      chk("idle_valid", 40'(res_valid), 40'd0);
    end
    run_slot(8'd7, 8'd9, 1'b1, 1'b1, 1'b0);
    chk("idle_then_seq", 40'(res_seq), 40'd0);
    res_ready = 1'b1;
    run_slot(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Overflow: four fit, the fifth is dropped but still consumes a sequence number.
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) run_slot(8'(i + 1), 8'd3, 1'b1, 1'b1, 1'b0);
    chk("full_no_ovf", 40'(overflow), 40'd0);
    run_slot(8'd5, 8'd3, 1'b1, 1'b0, 1'b0);
    chk("ovf_set", 40'(overflow), 40'd1);
    chk("ovf_drops", 40'(drop_count), 40'd1);
    res_ready = 1'b1;
    run_slot(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("drain_ovf", 40'(exp_q.size()), 40'd0);
    chk("ovf_sticky", 40'(overflow), 40'd1);
    run_slot(8'd6, 8'd7, 1'b1, 1'b1, 1'b0);
    chk("seq_after_gap", 40'(res_seq), 40'd5);
    run_slot(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Full FIFO with a pop on the capture edge: push accepted, still full afterwards.
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) run_slot(8'(i + 20), 8'd2, 1'b1, 1'b1, 1'b0);
    run_slot(8'd9, 8'd9, 1'b1, 1'b1, 1'b1);
    chk("swap_no_ovf", 40'(overflow), 40'd0);
    chk("swap_no_drop", 40'(drop_count), 40'd0);
    run_slot(8'd10, 8'd10, 1'b1, 1'b0, 1'b0);
    chk("swap_still_full", 40'(drop_count), 40'd1);
    res_ready = 1'b1;
    run_slot(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("drain_swap", 40'(exp_q.size()), 40'd0);
    chk("drain_swap_valid", 40'(res_valid), 40'd0);

    // Reset mid-slot with two entries queued discards everything.
    do_reset();
    res_ready = 1'b0;
    run_slot(8'd30, 8'd2, 1'b1, 1'b1, 1'b0);
    run_slot(8'd31, 8'd2, 1'b1, 1'b1, 1'b0);
    op_a = 8'd3; op_b = 8'd4; op_live = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_phase", 40'(phase), 40'd5);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    tb_seq = 8'd0;
    chk("mid_valid", 40'(res_valid), 40'd0);
    chk("mid_overflow", 40'(overflow), 40'd0);
    chk("mid_drops", 40'(drop_count), 40'd0);
    chk("mid_head", {res_data, res_a, res_b, res_seq}, 40'd0);
    rst = 1'b1;
    op_live = 1'b0;
    chk("release_phase", 40'(phase), 40'd0);
    res_ready = 1'b1;
    run_slot(8'd2, 8'd8, 1'b1, 1'b1, 1'b0);
    chk("post_reset_seq", 40'(res_seq), 40'd0);
    run_slot(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    chk("final_queue_empty", 40'(exp_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
